// File: rtl/amstrad_io_pkg.sv
// Shared types and constants for the Amstrad I/O write replayer.
package amstrad_io_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD,
        ST_RELEASE
    } state_t;

    // Queued OUT cycle: port address plus data byte (24 bits)
    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  data;
    } io_req_t;

    localparam logic [15:0] PORT_GA     = 16'h7FFF;
    localparam logic [15:0] PORT_ROMSEL = 16'hDFFF;
    localparam logic [1:0]  GA_MMR      = 2'b11;   // gate-array function code in D[7:6]

    function automatic int cyc_max(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/amstrad_io_fifo.sv
// Request FIFO for queued I/O writes; a push into a full FIFO is taken
// only when the head is being popped in the same cycle.
module amstrad_io_fifo
    import amstrad_io_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic    i_clk,
    input  logic    i_reset_n,
    input  logic    i_push,
    input  logic    i_pop,
    input  io_req_t i_data,
    output io_req_t o_data,
    output logic    o_full,
    output logic    o_empty
);
    localparam int AW = $clog2(DEPTH);

    io_req_t         r_mem [DEPTH];
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [AW:0]     r_count;
    logic            w_push;
    logic            w_pop;

    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_pop   = i_pop && !o_empty;
    assign w_push  = i_push && (!o_full || w_pop);
    assign o_data  = r_mem[r_rptr];

    // Storage write; contents need no reset since count gates visibility
    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wptr] <= i_data;
    end

    // Pointer and occupancy tracking, pointers wrap naturally modulo DEPTH
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/amstrad_io_replay.sv
// Replays queued Z80-style OUT cycles onto the motherboard I/O bus while
// holding bus ownership; used to restore RAM map / ROM bank without CPU code.
module amstrad_io_replay
    import amstrad_io_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int SETUP_CYC  = 1,
    parameter int STROBE_CYC = 2,
    parameter int HOLD_CYC   = 1
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic [15:0] i_req_addr,
    input  logic [7:0]  i_req_data,
    output logic        o_bus_req,
    input  logic        i_bus_ack,
    output logic        o_io_wr,
    output logic [15:0] o_io_a,
    output logic [7:0]  o_io_d,
    output logic        o_busy,
    output logic        o_done
);
    localparam int CW = $clog2(cyc_max(SETUP_CYC, STROBE_CYC, HOLD_CYC)) + 1;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic            r_bus_req;
    logic            r_io_wr;
    logic [15:0]     r_io_a;
    logic [7:0]      r_io_d;
    logic            r_done;

    io_req_t         w_in;
    io_req_t         w_head;
    logic            w_full;
    logic            w_empty;
    logic            w_push;
    logic            w_pop;

    assign w_in.addr   = i_req_addr;
    assign w_in.data   = i_req_data;
    // Entry leaves the FIFO on the edge that moves STROBE into HOLD
    assign w_pop       = (r_state == ST_STROBE) && (r_cnt == '0) && i_bus_ack;
    assign o_req_ready = !w_full || w_pop;
    assign w_push      = i_req_valid && o_req_ready;
    assign o_busy      = !w_empty || (r_state != ST_IDLE);
    assign o_bus_req   = r_bus_req;
    assign o_io_wr     = r_io_wr;
    assign o_io_a      = r_io_a;
    assign o_io_d      = r_io_d;
    assign o_done      = r_done;

    amstrad_io_fifo #(.DEPTH(DEPTH)) u_fifo (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_push    (w_push),
        .i_pop     (w_pop),
        .i_data    (w_in),
        .o_data    (w_head),
        .o_full    (w_full),
        .o_empty   (w_empty)
    );

    // Bus-cycle sequencer; a lost bus_ack mid-write falls back to REQ and
    // the unpopped head is replayed once the bus is granted again
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_bus_req <= 1'b0;
            r_io_wr   <= 1'b0;
            r_io_a    <= '0;
            r_io_d    <= '0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (!w_empty) begin
                        r_state   <= ST_REQ;
                        r_bus_req <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (i_bus_ack) begin
                        r_state <= ST_SETUP;
                        r_cnt   <= CW'(SETUP_CYC - 1);
                        r_io_a  <= w_head.addr;
                        r_io_d  <= w_head.data;
                    end
                end
                ST_SETUP: begin
                    if (!i_bus_ack) begin
                        r_state <= ST_REQ;
                    end else if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        r_state <= ST_STROBE;
                        r_cnt   <= CW'(STROBE_CYC - 1);
                        r_io_wr <= 1'b1;
                    end
                end
                ST_STROBE: begin
                    if (!i_bus_ack) begin
                        r_state <= ST_REQ;
                        r_io_wr <= 1'b0;
                    end else if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        r_state <= ST_HOLD;
                        r_cnt   <= CW'(HOLD_CYC - 1);
                        r_io_wr <= 1'b0;
                    end
                end
                ST_HOLD: begin
                    if (!i_bus_ack) begin
                        r_state <= ST_REQ;
                    end else if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else if (!w_empty) begin
                        // keep the bus and chain straight into the next write
                        r_state <= ST_SETUP;
                        r_cnt   <= CW'(SETUP_CYC - 1);
                        r_io_a  <= w_head.addr;
                        r_io_d  <= w_head.data;
                    end else begin
                        r_state   <= ST_RELEASE;
                        r_bus_req <= 1'b0;
                        r_io_a    <= '0;
                        r_io_d    <= '0;
                        r_done    <= 1'b1;
                    end
                end
                ST_RELEASE: r_state <= ST_IDLE;
                default:    r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
